sobel_gradient: RTL and testbench

- Upstream producer of the signed Sobel gradient pair consumed by the magnitude/threshold stage.
- Accepts a raster-order 8-bit greyscale pixel stream and holds two line buffers plus a 3x3 window.
- Emits scaled 9-bit signed sobelX/sobelY for every interior pixel, with a valid strobe and an end-of-frame pulse.

---
 rtl/sobel_gradient.sv | 93 +++++++++
 tb/tb_sobel_gradient.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient.sv
// Sobel gradient stage: two line buffers and a 3x3 window produce scaled signed Gx/Gy for each interior pixel.
// Latency 1 cycle after the completing pixel; pixValid=0 stalls all state and gradValid stays low.
module sobel_gradient #(
  parameter int IMGW = 1024,
  parameter int IMGH = 512,
  parameter int COLW = 10,
  parameter int ROWW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pixIn,
  input  logic              pixValid,
  input  logic              sof,
  output logic signed [8:0] sobelX,
  output logic signed [8:0] sobelY,
  output logic              gradValid,
  output logic              frameDone
);

  localparam logic [COLW-1:0] COLMAX = COLW'(IMGW - 1);
  localparam logic [ROWW-1:0] ROWMAX = ROWW'(IMGH - 1);

  logic [COLW-1:0] col, c;
  logic [ROWW-1:0] row, r;

  logic [7:0] lb0 [IMGW];
  logic [7:0] lb1 [IMGW];
  logic [7:0] t0, t1;

  logic [7:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;

  logic signed [10:0] gx, gy;
  logic               interior;
  logic               lastPix;
  logic               unusedBits;

  // sof overrides the running position so the pixel lands at (0,0).
  always_comb begin
    c  = sof ? '0 : col;
    r  = sof ? '0 : row;
    t1 = lb1[c];
    t0 = lb0[c];
    // Taps are taken from the window as it will look after this pixel shifts in.
    gx = ({3'b0, t1} + {2'b0, t0, 1'b0} + {3'b0, pixIn})
       - ({3'b0, w01} + {2'b0, w11, 1'b0} + {3'b0, w21});
    gy = ({3'b0, w21} + {2'b0, w22, 1'b0} + {3'b0, pixIn})
       - ({3'b0, w01} + {2'b0, w02, 1'b0} + {3'b0, t1});
    interior = (r >= ROWW'(2)) && (c >= COLW'(2));
    lastPix  = (r == ROWMAX) && (c == COLMAX);
  end

  assign unusedBits = ^{gx[1:0], gy[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      {w00, w01, w02, w10, w11, w12, w20, w21, w22} <= '0;
      sobelX    <= '0;
      sobelY    <= '0;
      gradValid <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      gradValid <= pixValid && interior;
      frameDone <= pixValid && interior && lastPix;
      if (pixValid) begin
        if (c == COLMAX) begin
          col <= '0;
          row <= (r == ROWMAX) ? '0 : r + ROWW'(1);
        end else begin
          col <= c + COLW'(1);
          row <= r;
        end
        w00 <= w01; w01 <= w02; w02 <= t1;
        w10 <= w11; w11 <= w12; w12 <= t0;
        w20 <= w21; w21 <= w22; w22 <= pixIn;
        if (interior) begin
          // Arithmetic shift by 2 floors; the top 9 bits carry the scaled result.
          sobelX <= gx[10:2];
          sobelY <= gy[10:2];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pixValid) begin
      lb1[c] <= t0;
      lb0[c] <= pixIn;
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed-vector bench for sobel_gradient on an 8x6 image.
module tb_sobel_gradient;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    int pat;
    bit gaps;
    bit axisRow;
    int lo;
    int hi;
    int xin;
    int yin;
    int xout;
    int yout;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        pixIn = 8'd0;
  logic              pixValid = 1'b0;
  logic              sof = 1'b0;
  logic signed [8:0] sobelX, sobelY;
  logic              gradValid, frameDone;

  int tests = 0;
  int fails = 0;
  bit lastValid = 1'b0;
  int qx[$];
  int qy[$];
  int qfd[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  sobel_gradient #(.IMGW(W), .IMGH(H), .COLW(3), .ROWW(3)) dut (
    .clk(clk), .reset(reset), .pixIn(pixIn), .pixValid(pixValid), .sof(sof),
    .sobelX(sobelX), .sobelY(sobelY), .gradValid(gradValid), .frameDone(frameDone)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Samples the result of the previous edge, then drives the next input.
  task automatic cycle(input bit v, input logic [7:0] p, input bit s);
    @(negedge clk);
    if (gradValid) begin
      chk("valid_follows_accept", int'(lastValid), 1);
      qx.push_back(int'(sobelX));
      qy.push_back(int'(sobelY));
      qfd.push_back(int'(frameDone));
    end
    pixValid  = v;
    pixIn     = p;
    sof       = s;
    lastValid = v;
  endtask

  function automatic logic [7:0] pixf(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd200;
      2:       return (c < 4) ? 8'd200 : 8'd0;
      3:       return (r < 3) ? 8'd0 : 8'd200;
      4:       return 8'(c * 3);
      default: return 8'(r);
    endcase
  endfunction

  task automatic clearq();
    qx.delete();
    qy.delete();
    qfd.delete();
  endtask

  task automatic send(input int pat, input bit gaps, input bit firstSof, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 5)) cycle(1'b0, 8'd0, 1'b0);
      cycle(1'b1, pixf(pat, i / W, i % W), firstSof && (i == 0));
    end
    repeat (3) cycle(1'b0, 8'd0, 1'b0);
  endtask

  task automatic check_frame(input vec_t v, input int idx);
    int r, c, pos;
    bit inreg;
    chk($sformatf("v%0d_pulses", idx), qx.size(), (W - 2) * (H - 2));
    for (int i = 0; i < qx.size() && i < (W - 2) * (H - 2); i++) begin
      r     = 1 + i / (W - 2);
      c     = 1 + i % (W - 2);
      pos   = v.axisRow ? r : c;
      inreg = (pos >= v.lo) && (pos <= v.hi);
      chk($sformatf("v%0d_x(%0d,%0d)", idx, r, c), qx[i], inreg ? v.xin : v.xout);
      chk($sformatf("v%0d_y(%0d,%0d)", idx, r, c), qy[i], inreg ? v.yin : v.yout);
      chk($sformatf("v%0d_fd(%0d,%0d)", idx, r, c), qfd[i], (i == (W - 2) * (H - 2) - 1) ? 1 : 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sobelX"}, int'(sobelX), 0);
    chk({tag, "_sobelY"}, int'(sobelY), 0);
    chk({tag, "_gradValid"}, int'(gradValid), 0);
    chk({tag, "_frameDone"}, int'(frameDone), 0);
  endtask

  initial begin
    int plen[2];
    int pexp[2];
    int fdsum;

    //          pat gaps row lo hi  xin   yin xout yout
    vecs[0] = '{0, 0, 0, 1, 6,    0,    0, 0, 0};
    vecs[1] = '{1, 0, 0, 3, 4,  200,    0, 0, 0};
    vecs[2] = '{2, 0, 0, 3, 4, -200,    0, 0, 0};
    vecs[3] = '{3, 0, 1, 2, 3,    0,  200, 0, 0};
    vecs[4] = '{4, 0, 0, 1, 6,    6,    0, 0, 0};
    vecs[5] = '{5, 0, 1, 1, 4,    0,    2, 0, 0};
    vecs[6] = '{1, 1, 0, 3, 4,  200,    0, 0, 0};
    vecs[7] = '{3, 1, 1, 2, 3,    0,  200, 0, 0};
    vecs[8] = '{4, 1, 0, 1, 6,    6,    0, 0, 0};
    plen[0] = 20; pexp[0] = 2;
    plen[1] = 47; pexp[1] = 23;

    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      clearq();
      send(vecs[k].pat, vecs[k].gaps, 1'b1, W * H);
      check_frame(vecs[k], k);
    end

    // Reset in the middle of row 3, then a frame with no sof.
    clearq();
    send(4, 1'b0, 1'b1, 3 * W + 4);
    chk("pre_reset_sobelX", int'(sobelX), 6);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    clearq();
    send(1, 1'b0, 1'b0, W * H);
    check_frame(vecs[1], 100);

    // Truncated frames restarted by sof; the 47-pixel case puts sof on the last-pixel slot.
    for (int p = 0; p < 2; p++) begin
      clearq();
      send(1, 1'b0, 1'b1, plen[p]);
      chk($sformatf("partial%0d_pulses", p), qx.size(), pexp[p]);
      fdsum = 0;
      foreach (qfd[i]) fdsum += qfd[i];
      chk($sformatf("partial%0d_frameDone", p), fdsum, 0);
      clearq();
      send(1, 1'b0, 1'b1, W * H);
      check_frame(vecs[1], 200 + p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
